// File: rtl/buf_alloc_aging.sv
// buf_alloc_aging
// Free-buffer allocator with per-buffer aging. Free addresses from the
// address manager go into a 16-entry circular free list and are handed out
// one per request. Every allocated buffer has an age counter that advances
// on a prescaled tick. A round-robin scanner returns expired buffers to the
// manager's aging recycle port. A release from the output path ends aging
// for that buffer.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low
//   buf_addr_wr/buf_addr   free address push from the address manager
//   alloc_req              allocation request strobe
//   alloc_ack/alloc_nack   one-cycle grant/refuse pulse, one cycle after request
//   alloc_addr             granted address (holds its value across a nack)
//   rel_wr/rel_addr        release strobe from the packet-output stage
//   aging_recycle_addr_wr  one-cycle pulse when a buffer expires
//   aging_recycle_addr     expired address
//   free_count             free list occupancy, 0..16
//   err_flag               sticky: write into full list or release of a free buffer
module buf_alloc_aging #(
  parameter int               AGE_W     = 8,
  parameter logic [AGE_W-1:0] AGE_LIMIT = 8'd200,
  parameter logic [15:0]      TICK_DIV  = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       buf_addr_wr,
  input  logic [3:0] buf_addr,
  input  logic       alloc_req,
  output logic       alloc_ack,
  output logic       alloc_nack,
  output logic [3:0] alloc_addr,
  input  logic       rel_wr,
  input  logic [3:0] rel_addr,
  output logic       aging_recycle_addr_wr,
  output logic [3:0] aging_recycle_addr,
  output logic [4:0] free_count,
  output logic       err_flag
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [3:0]       fifo [16];
  logic [3:0]       rd_ptr;
  logic [3:0]       wr_ptr;
  logic [3:0]       scan_ptr;
  logic [15:0]      presc;
  logic [15:0]      in_use;
  logic [15:0]      in_use_nxt;
  logic [AGE_W-1:0] age [16];

  logic       tick;
  logic       do_rd;
  logic       do_wr;
  logic       wr_drop;
  logic       rel_ok;
  logic       rel_bad;
  logic       expire;
  logic [3:0] rd_addr;

  assign tick    = (presc == TICK_DIV - 16'd1);
  assign rd_addr = fifo[rd_ptr];
  assign do_rd   = alloc_req && (free_count != 5'd0);
  // Occupancy is judged before this cycle's read, so a full list drops the
  // write even when a read happens in the same cycle.
  assign do_wr   = buf_addr_wr && (free_count != 5'd16);
  assign wr_drop = buf_addr_wr && (free_count == 5'd16);
  assign rel_ok  = rel_wr && in_use[rel_addr];
  assign rel_bad = rel_wr && !in_use[rel_addr];

  // Release and allocation of the scanned address both suppress expiry.
  assign expire = in_use[scan_ptr] && (age[scan_ptr] >= AGE_LIMIT)
                  && !(rel_wr && (rel_addr == scan_ptr))
                  && !(do_rd && (rd_addr == scan_ptr));

  // Later assignments win: allocation overrides a clear of the same address.
  always_comb begin
    in_use_nxt = in_use;
    if (expire) in_use_nxt[scan_ptr] = 1'b0;
    if (rel_ok) in_use_nxt[rel_addr] = 1'b0;
    if (do_rd)  in_use_nxt[rd_addr]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      scan_ptr              <= '0;
      presc                 <= '0;
      in_use                <= '0;
      free_count            <= '0;
      err_flag              <= 1'b0;
      alloc_ack             <= 1'b0;
      alloc_nack            <= 1'b0;
      alloc_addr            <= '0;
      aging_recycle_addr_wr <= 1'b0;
      aging_recycle_addr    <= '0;
      for (int i = 0; i < 16; i++) begin
        fifo[i] <= '0;
        age[i]  <= '0;
      end
    end else begin
      presc    <= tick ? 16'd0 : presc + 16'd1;
      scan_ptr <= scan_ptr + 4'd1;
      in_use   <= in_use_nxt;

      if (do_wr) begin
        fifo[wr_ptr] <= buf_addr;
        wr_ptr       <= wr_ptr + 4'd1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 4'd1;
      free_count <= free_count + {4'd0, do_wr} - {4'd0, do_rd};
      err_flag   <= err_flag | wr_drop | rel_bad;

      alloc_ack  <= do_rd;
      alloc_nack <= alloc_req && (free_count == 5'd0);
      if (do_rd) alloc_addr <= rd_addr;

      aging_recycle_addr_wr <= expire;
      if (expire) aging_recycle_addr <= scan_ptr;

      for (int i = 0; i < 16; i++) begin
        if (do_rd && (rd_addr == 4'(i)))
          age[i] <= '0;
        else if (tick && in_use[i] && (age[i] != AGE_MAX))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_buf_alloc_aging.sv
module tb_buf_alloc_aging;

  localparam int TDIV = 4;
  localparam int LIM  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       buf_addr_wr = 1'b0;
  logic [3:0] buf_addr = '0;
  logic       alloc_req = 1'b0;
  logic       alloc_ack;
  logic       alloc_nack;
  logic [3:0] alloc_addr;
  logic       rel_wr = 1'b0;
  logic [3:0] rel_addr = '0;
  logic       aging_recycle_addr_wr;
  logic [3:0] aging_recycle_addr;
  logic [4:0] free_count;
  logic       err_flag;

  buf_alloc_aging #(.AGE_W(8), .AGE_LIMIT(8'd3), .TICK_DIV(16'd4)) dut (
    .clk(clk), .reset(reset),
    .buf_addr_wr(buf_addr_wr), .buf_addr(buf_addr),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_nack(alloc_nack),
    .alloc_addr(alloc_addr),
    .rel_wr(rel_wr), .rel_addr(rel_addr),
    .aging_recycle_addr_wr(aging_recycle_addr_wr),
    .aging_recycle_addr(aging_recycle_addr),
    .free_count(free_count), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: free list as a queue, buffer state as plain arrays,
  // prescaler and scanner derived from the number of edges since reset.
  int unsigned m_q[$];
  bit          m_inuse[16];
  int          m_age[16];
  int          m_cyc = 0;
  bit          m_ack = 0, m_nack = 0, m_rec = 0, m_err = 0;
  int          m_addr = 0, m_rec_addr = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_q.delete();
      for (int i = 0; i < 16; i++) begin m_inuse[i] = 0; m_age[i] = 0; end
      m_cyc = 0; m_ack = 0; m_nack = 0; m_rec = 0; m_err = 0;
      m_addr = 0; m_rec_addr = 0;
    end else begin
      int  n, s, a;
      bit  rd, ex;
      bit  nu[16];
      int  na[16];
      n  = m_q.size();
      s  = m_cyc % 16;
      rd = alloc_req && n > 0;
      a  = rd ? int'(m_q[0]) : 0;
      nu = m_inuse;
      na = m_age;
      if ((m_cyc % TDIV) == TDIV - 1)
        for (int i = 0; i < 16; i++) if (m_inuse[i] && na[i] < 255) na[i]++;
      ex = m_inuse[s] && m_age[s] >= LIM && !(rel_wr && int'(rel_addr) == s)
           && !(rd && a == s);
      if (ex) nu[s] = 0;
      if (rel_wr) begin
        if (m_inuse[rel_addr]) nu[rel_addr] = 0;
        else m_err = 1;
      end
      if (rd) begin
        nu[a] = 1;
        na[a] = 0;
        void'(m_q.pop_front());
      end
      if (buf_addr_wr) begin
        if (n < 16) m_q.push_back(int'(buf_addr));
        else m_err = 1;
      end
      m_ack  = rd;
      m_nack = alloc_req && n == 0;
      if (rd) m_addr = a;
      m_rec = ex;
      if (ex) m_rec_addr = s;
      m_inuse = nu;
      m_age   = na;
      m_cyc++;
    end
  end

  // Cycle compare against the model.
  initial forever begin
    @(negedge clk);
    chk("cmp_ack", alloc_ack, m_ack);
    chk("cmp_nack", alloc_nack, m_nack);
    chk("cmp_addr", alloc_addr, m_addr);
    chk("cmp_rec", aging_recycle_addr_wr, m_rec);
    if (m_rec) chk("cmp_rec_addr", aging_recycle_addr, m_rec_addr);
    chk("cmp_free_count", free_count, m_q.size());
    chk("cmp_err", err_flag, m_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0;
    buf_addr_wr = 1'b0; buf_addr = '0; alloc_req = 1'b0;
    rel_wr = 1'b0; rel_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      buf_addr_wr = 1'b1;
      buf_addr    = 4'(i);
      @(negedge clk);
    end
    buf_addr_wr = 1'b0;
  endtask

  task automatic alloc_one(input logic [3:0] a, input string nm);
    buf_addr_wr = 1'b1; buf_addr = a;
    @(negedge clk);
    buf_addr_wr = 1'b0; alloc_req = 1'b1;
    @(negedge clk);
    alloc_req = 1'b0;
    chk({nm, "_ack"}, alloc_ack, 1);
    chk({nm, "_addr"}, alloc_addr, a);
  endtask

  initial begin
    int first_c, pulses, paddr;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_free_count", free_count, 0);
    chk("rst_err", err_flag, 0);
    chk("rst_ack", alloc_ack, 0);
    chk("rst_rec", aging_recycle_addr_wr, 0);

    // fill, then overflow
    do_reset();
    fill16();
    chk("fill_count", free_count, 16);
    chk("fill_err", err_flag, 0);
    buf_addr_wr = 1'b1; buf_addr = 4'd9;
    @(negedge clk);
    buf_addr_wr = 1'b0;
    chk("ovf_count", free_count, 16);
    chk("ovf_err", err_flag, 1);

    // 17 back-to-back requests on a full list
    do_reset();
    fill16();
    for (int i = 0; i < 17; i++) begin
      alloc_req = 1'b1;
      @(negedge clk);
      if (i < 16) begin
        chk("b2b_ack", alloc_ack, 1);
        chk("b2b_addr", alloc_addr, i);
      end else begin
        chk("b2b_nack", alloc_nack, 1);
        chk("b2b_nack_ack", alloc_ack, 0);
        chk("b2b_nack_addr_hold", alloc_addr, 15);
      end
    end
    alloc_req = 1'b0;
    chk("b2b_count", free_count, 0);

    // no bypass: write and request on an empty list
    do_reset();
    buf_addr_wr = 1'b1; buf_addr = 4'd5; alloc_req = 1'b1;
    @(negedge clk);
    buf_addr_wr = 1'b0;
    chk("nobyp_nack", alloc_nack, 1);
    chk("nobyp_ack", alloc_ack, 0);
    @(negedge clk);
    alloc_req = 1'b0;
    chk("nobyp_ack2", alloc_ack, 1);
    chk("nobyp_addr2", alloc_addr, 5);

    // expiry of addr 2: ack edge 1, age 3 after edge 11, scanned at edge 18
    do_reset();
    alloc_one(4'd2, "exp");
    first_c = -1; pulses = 0; paddr = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (aging_recycle_addr_wr) begin
        pulses++;
        if (first_c < 0) begin first_c = c; paddr = aging_recycle_addr; end
      end
    end
    chk("exp_seen", first_c >= 0, 1);
    chk("exp_addr", paddr, 2);
    chk("exp_latency", first_c, 17);
    chk("exp_window", first_c >= 12 && first_c <= 28, 1);
    chk("exp_single", pulses, 1);

    // release stops aging; second release is an error
    do_reset();
    alloc_one(4'd7, "rel");
    repeat (8) @(negedge clk);
    rel_wr = 1'b1; rel_addr = 4'd7;
    @(negedge clk);
    rel_wr = 1'b0;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (aging_recycle_addr_wr) pulses++;
    end
    chk("rel_no_pulse", pulses, 0);
    chk("rel_err_clean", err_flag, 0);
    rel_wr = 1'b1; rel_addr = 4'd7;
    @(negedge clk);
    rel_wr = 1'b0;
    chk("rel_double_err", err_flag, 1);

    // release in the exact cycle the scanner finds addr 3 expired (edge 19)
    do_reset();
    alloc_one(4'd3, "race");
    for (int c = 0; c < 50 && m_cyc < 19; c++) @(negedge clk);
    chk("race_at_edge", m_cyc, 19);
    rel_wr = 1'b1; rel_addr = 4'd3;
    @(negedge clk);
    rel_wr = 1'b0;
    chk("race_no_pulse", aging_recycle_addr_wr, 0);
    chk("race_err", err_flag, 0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (aging_recycle_addr_wr) pulses++;
    end
    chk("race_inuse_cleared", pulses, 0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
